cntr_4_ctrl: RTL and testbench

Run controller for the 4-bit counter `cntr_4`. It owns the counter's `rst` and `ce` pins: clears it, paces count enables through a programmable prescaler, detects the terminal value and either stops (one-shot) or re-clears and keeps running (auto-reload). It sits between the command/host logic and `cntr_4`, and reads the counter's `out` back for terminal detection.

---
 rtl/cntr_4_ctrl.sv | 128 ++++++++++++
 tb/tb_cntr_4_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cntr_4_ctrl.sv
// cntr_4_ctrl: run controller for the 4-bit counter cntr_4.
// Clears the counter, paces its count enable through a prescaler, and on
// reaching the terminal value either stops (one-shot) or re-clears and keeps
// running (auto-reload).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             command pulse, starts a run from IDLE
//   abort             ends a run in CLEAR/RUN; counter keeps its value
//   reload            0 = one-shot, 1 = auto-reload (sampled with start)
//   limit [3:0]       terminal count (sampled with start)
//   div [DIV_W-1:0]   prescaler, cntr_ce period is div+1 cycles
//   cnt [3:0]         counter value read back from cntr_4.out
//   cntr_rst, cntr_ce drive cntr_4.rst / cntr_4.ce
//   busy              high in CLEAR and RUN
//   done              one-cycle pulse when a one-shot run completes
//   tick              one-cycle pulse on every auto-reload wrap
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start, counter holds its value
// CLEAR | one cycle, counter cleared, prescaler zeroed
// RUN   | counting toward limit_q
// DONE  | one cycle, one-shot run finished
module cntr_4_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             reload,
  input  logic [3:0]       limit,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       cnt,
  output logic             cntr_rst,
  output logic             cntr_ce,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] pre, pre_nxt;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       limit_q;
  logic             reload_q;
  logic             load;
  logic             at_lim;
  logic             in_run;
  logic             wrap;

  assign at_lim = (cnt == limit_q);
  assign in_run = (state == RUN);
  // Auto-reload wrap: clear the counter instead of enabling it.
  assign wrap   = in_run & at_lim & reload_q & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pre      <= '0;
      limit_q  <= '0;
      div_q    <= '0;
      reload_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      if (load) begin
        limit_q  <= limit;
        div_q    <= div;
        reload_q <= reload;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        pre_nxt   = '0;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (at_lim && !reload_q) begin
          state_nxt = DONE;
        end else if (at_lim) begin
          pre_nxt = '0;
        end else begin
          pre_nxt = (pre == div_q) ? '0 : pre + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The registered state may still be non-IDLE in the first reset cycle, so
  // the decodes are masked by rst to keep outputs quiet while it is applied.
  always_comb begin
    cntr_rst = rst | (state == CLEAR) | wrap;
    cntr_ce  = ~rst & in_run & ~at_lim & (pre == div_q) & ~abort;
    busy     = ~rst & ((state == CLEAR) | in_run);
    done     = ~rst & (state == DONE);
    tick     = ~rst & wrap;
  end

endmodule

// File: tb/tb_cntr_4_ctrl.sv
module tb_cntr_4_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, reload;
  logic [3:0] limit;
  logic [7:0] div;
  logic [3:0] cnt;
  logic       cntr_rst, cntr_ce, busy, done, tick;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Behavioural cntr_4: synchronous clear has priority over count enable.
  always_ff @(posedge clk) begin
    if (cntr_rst)     cnt <= 4'd0;
    else if (cntr_ce) cnt <= cnt + 4'd1;
  end

  cntr_4_ctrl #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .reload(reload),
    .limit(limit), .div(div), .cnt(cnt),
    .cntr_rst(cntr_rst), .cntr_ce(cntr_ce), .busy(busy), .done(done),
    .tick(tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge; start is sampled at the next edge (edge 0) and the
  // call returns in cycle 1.
  task automatic do_start(input int l, input int d, input logic r);
    start  = 1'b1;
    limit  = 4'(l);
    div    = 8'(d);
    reload = r;
    cyc    = 0;
    step();
    start  = 1'b0;
  endtask

  int ce_cnt, done_cyc, max_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; reload = 1'b0;
    limit = 4'd0; div = 8'd0;

    // Reset then idle
    @(negedge clk);
    chk("rst_cntr_rst", cntr_rst, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_quiet", {cntr_ce, busy, done, tick}, 0);
    @(negedge clk);
    chk("rst2_cntr_rst", cntr_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {cntr_rst, cntr_ce, busy, done, tick}, 0);
    @(negedge clk);
    chk("idle_cnt", cnt, 0);

    // One-shot, limit 3, div 1
    do_start(3, 1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      chk("os_ce", cntr_ce, int'(c == 3 || c == 5 || c == 7));
      chk("os_done", done, int'(c == 9));
      chk("os_busy", busy, int'(c >= 1 && c <= 8));
      chk("os_cnt", cnt, (c < 4) ? 0 : (c < 6) ? 1 : (c < 8) ? 2 : 3);
      chk("os_tick", tick, 0);
      step();
    end

    // Reload, limit 2, div 0; cnt was 3, cleared by CLEAR
    do_start(2, 0, 1'b1);
    chk("rl_clear_rst", cntr_rst, 1);
    step();
    for (int c = 2; c <= 11; c++) begin
      chk("rl_cnt", cnt, (c - 2) % 3);
      chk("rl_tick", tick, int'((c - 2) % 3 == 2));
      chk("rl_rst", cntr_rst, int'((c - 2) % 3 == 2));
      chk("rl_done", done, 0);
      chk("rl_busy", busy, 1);
      step();
    end
    // cycle 12: cnt = 1, abort now
    chk("ab_cnt_pre", cnt, 1);
    abort = 1'b1;
    #1;
    chk("ab_ce_gated", cntr_ce, 0);
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_cnt", cnt, 1);
    step();
    chk("ab_cnt_hold", cnt, 1);
    chk("ab_no_pulse", {done, tick}, 0);

    // limit 0 one-shot: done at cycle 3, no ce
    ce_cnt = 0;
    do_start(0, 5, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      ce_cnt += int'(cntr_ce);
      chk("l0_done", done, int'(c == 3));
      step();
    end
    chk("l0_ce_count", ce_cnt, 0);

    // limit 0 reload: tick + cntr_rst every RUN cycle
    do_start(0, 3, 1'b1);
    step();
    for (int c = 2; c <= 6; c++) begin
      chk("l0r_tick_rst_ce", {tick, cntr_rst, cntr_ce}, 3'b110);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("l0r_abort_busy", busy, 0);

    // limit 15, div 255: done at cycle 3843, no wrap
    ce_cnt = 0; done_cyc = -1; max_cnt = 0;
    do_start(15, 255, 1'b0);
    for (int c = 1; c <= 4000; c++) begin
      ce_cnt += int'(cntr_ce);
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      if (done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc + 2) break;
      step();
    end
    chk("l15_done_cyc", done_cyc, 3843);
    chk("l15_ce_count", ce_cnt, 15);
    chk("l15_cnt", cnt, 15);
    chk("l15_max", max_cnt, 15);

    // start + abort in the same IDLE cycle: run starts
    abort = 1'b1;
    do_start(4, 0, 1'b0);
    chk("sa_busy", busy, 1);
    chk("sa_clear", cntr_rst, 1);
    step();
    abort = 1'b0;
    chk("sa_abort_clear", busy, 0);

    // Re-start during RUN ignored: limit 2, div 1 -> done at cycle 7
    done_cyc = -1;
    do_start(2, 1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        start = 1'b1; limit = 4'd5; div = 8'd0; reload = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done && done_cyc < 0) done_cyc = c;
      step();
    end
    start = 1'b0;
    chk("rs_done_cyc", done_cyc, 7);
    chk("rs_cnt", cnt, 2);
    chk("rs_idle", busy, 0);

    // rst mid-run: limit 10, div 0
    do_start(10, 0, 1'b0);
    step(); step(); step(); step();
    chk("mr_cnt_pre", cnt, 3);
    rst = 1'b1;
    #1;
    chk("mr_during", {cntr_rst, cntr_ce, busy, done, tick}, 5'b10000);
    step();
    rst = 1'b0;
    chk("mr_cnt", cnt, 0);
    chk("mr_busy", busy, 0);
    done_cyc = 0;
    for (int c = 0; c < 15; c++) begin
      done_cyc += int'(done);
      step();
    end
    chk("mr_no_done", done_cyc, 0);
    chk("mr_cnt_hold", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
